// File: rtl/bit_ram_word_master_if.sv
// Request/response channel between a datapath and one bit_ram_word_master.
// The datapath side uses modport master; the word master uses modport slave.
interface bit_ram_word_master_if #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 14
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/bit_ram_word_master.sv
// Serialises whole-word loads/stores into WORD_W single-bit accesses on one
// bit-RAM port. Optional store read-back check: BIT_RAM_MASTER_WRITE_VERIFY_EN.
module bit_ram_word_master #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  clear_n,
  bit_ram_word_master_if.slave  bus,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_datain,
  output logic                  mem_store,
  input  logic                  mem_dataout
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
`ifdef BIT_RAM_MASTER_WRITE_VERIFY_EN
    VERIFY,
`endif
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  bit_idx;
  logic              access;

  // count walks upward through addresses, so the word bit runs downward
  assign bit_idx = LAST - count_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      count_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    count_d = count_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          count_d = '0;
          // cleared here so a store without read-back answers with zero
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (!write_q) begin
          rdata_d[bit_idx] = mem_dataout;
        end
        if (count_q == LAST) begin
          count_d = '0;
`ifdef BIT_RAM_MASTER_WRITE_VERIFY_EN
          state_d = write_q ? VERIFY : RESP;
`else
          state_d = RESP;
`endif
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

`ifdef BIT_RAM_MASTER_WRITE_VERIFY_EN
      VERIFY: begin
        rdata_d[bit_idx] = mem_dataout;
        if (count_q == LAST) begin
          count_d = '0;
          err_d   = (rdata_d != wdata_q);
          state_d = RESP;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
`endif

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef BIT_RAM_MASTER_WRITE_VERIFY_EN
  assign access = (state_q == XFER) || (state_q == VERIFY);
`else
  assign access = (state_q == XFER);
`endif

  // RAM port is a pure decode of registered state
  assign mem_address = access ? (addr_q + ADDR_W'(count_q)) : '0;
  assign mem_store   = (state_q == XFER) && write_q;
  assign mem_datain  = mem_store & wdata_q[bit_idx];

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  a_store_only_in_xfer: assert property (
    @(posedge clk) disable iff (!clear_n) mem_store |-> (state_q == XFER)
  );

  a_no_accept_with_rsp: assert property (
    @(posedge clk) disable iff (!clear_n) !(bus.rsp_valid && bus.req_ready)
  );

endmodule

// File: tb/tb_bit_ram_word_master.sv
// Scoreboard bench for bit_ram_word_master: directed stores/loads against a
// behavioural bit RAM, plus a 12-bit instance reading a preloaded image.
module tb_bit_ram_word_master;

  localparam int W  = 8;
  localparam int A  = 14;
  localparam int W2 = 12;
  localparam logic [A-1:0] STUCK = 14'h0042;

`ifdef BIT_RAM_MASTER_WRITE_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif
  localparam int STORE_LAT = VERIFY_ON ? 2 * W : W;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance (WORD_W = 8) ----------------
  bit_ram_word_master_if #(.WORD_W(W), .ADDR_W(A)) bus ();
  logic [A-1:0] mem_address;
  logic         mem_datain, mem_store, mem_dataout;

  bit_ram_word_master #(.WORD_W(W), .ADDR_W(A)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .bus        (bus),
    .mem_address(mem_address),
    .mem_datain (mem_datain),
    .mem_store  (mem_store),
    .mem_dataout(mem_dataout)
  );

  logic         ram [0:(1<<A)-1];
  logic [A-1:0] wlog_addr [$];
  logic         wlog_data [$];

  assign mem_dataout = (mem_address == STUCK) ? 1'b0 : ram[mem_address];

  always @(posedge clk) begin
    if (mem_store) begin
      ram[mem_address] <= mem_datain;
      wlog_addr.push_back(mem_address);
      wlog_data.push_back(mem_datain);
    end
  end

  // ---------------- second instance (WORD_W = 12) ----------------
  bit_ram_word_master_if #(.WORD_W(W2), .ADDR_W(A)) bus2 ();
  logic [A-1:0] mem2_address;
  logic         mem2_datain, mem2_store, mem2_dataout;

  bit_ram_word_master #(.WORD_W(W2), .ADDR_W(A)) dut2 (
    .clk        (clk),
    .clear_n    (clear_n),
    .bus        (bus2),
    .mem_address(mem2_address),
    .mem_datain (mem2_datain),
    .mem_store  (mem2_store),
    .mem_dataout(mem2_dataout)
  );

  logic ram2 [0:(1<<A)-1];
  assign mem2_dataout = ram2[mem2_address];

  always @(posedge clk) begin
    if (mem2_store) ram2[mem2_address] <= mem2_datain;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] rdata;
    logic         err;
  } exp_t;

  exp_t          sbq  [$];
  logic [W2-1:0] sbq2 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clear_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (clear_n && bus2.rsp_valid && bus2.rsp_ready) begin
      if (sbq2.size() == 0) begin
        check("unexpected_rsp2", 32'(bus2.rsp_valid), 32'd0);
      end else begin
        logic [W2-1:0] e2;
        e2 = sbq2.pop_front();
        check("rsp2_rdata", 32'(bus2.rsp_rdata), 32'(e2));
        check("rsp2_err", 32'(bus2.rsp_err), 32'd0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic wr, input logic [A-1:0] addr, input logic [W-1:0] wd,
                       input bit push, input logic [W-1:0] er, input logic ee);
    int n;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 100);
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(bus.req_ready), 32'd1);
    end else if (push) begin
      exp_t e;
      e.rdata = er;
      e.err   = ee;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int exp_lat, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.rsp_valid && n < 200);
    check(name, 32'(n), 32'(exp_lat));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.rsp_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (bus.rsp_valid) check("rsp_stuck", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_wlog(input string name, input logic [A-1:0] base, input logic [W-1:0] v);
    logic [A-1:0] a;
    check({name, "_nwrites"}, 32'(wlog_addr.size()), 32'd8);
    for (int i = 0; i < W; i++) begin
      if (i < wlog_addr.size()) begin
        a = base + A'(i);
        check({name, "_waddr"}, 32'(wlog_addr[i]), 32'(a));
        check({name, "_wbit"}, 32'(wlog_data[i]), 32'(v[W-1-i]));
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [W2-1:0] img;
    int  n;
    bit  seen;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus2.req_valid = 1'b0;
    bus2.req_write = 1'b0;
    bus2.req_addr  = '0;
    bus2.req_wdata = '0;
    bus2.rsp_ready = 1'b1;

    img = 12'h538;
    for (int i = 0; i < (1 << A); i++) begin
      ram[i]  = 1'b0;
      ram2[i] = 1'b0;
    end
    for (int i = 0; i < W2; i++) ram2[i] = img[W2-1-i];

    // reset state
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mem_store", 32'(mem_store), 32'd0);
    check("rst_mem_datain", 32'(mem_datain), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    #1 clear_n = 1'b1;
    @(posedge clk);
    #1;

    // store 0xA5 @0x0010, then load it back
    wlog_addr.delete();
    wlog_data.delete();
    issue(1'b1, 14'h0010, 8'hA5, 1'b1, VERIFY_ON ? 8'hA5 : 8'h00, 1'b0);
    wait_rsp(STORE_LAT, "lat_store_a5");
    wait_done();
    check_wlog("a5", 14'h0010, 8'hA5);
    issue(1'b0, 14'h0010, 8'h00, 1'b1, 8'hA5, 1'b0);
    wait_rsp(W, "lat_load_a5");
    wait_done();

    // wrap across the top of the address space
    wlog_addr.delete();
    wlog_data.delete();
    issue(1'b1, 14'h3FFC, 8'h3C, 1'b1, VERIFY_ON ? 8'h3C : 8'h00, 1'b0);
    wait_rsp(STORE_LAT, "lat_store_wrap");
    wait_done();
    check_wlog("wrap", 14'h3FFC, 8'h3C);
    issue(1'b0, 14'h3FFC, 8'h00, 1'b1, 8'h3C, 1'b0);
    wait_rsp(W, "lat_load_wrap");
    wait_done();

    // backpressure with a pending request
    bus.rsp_ready = 1'b0;
    issue(1'b0, 14'h0010, 8'h00, 1'b1, 8'hA5, 1'b0);
    wait_rsp(W, "lat_load_bp");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 14'h3FFC;
    begin
      exp_t e;
      e.rdata = 8'h3C;
      e.err   = 1'b0;
      sbq.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata_stable", 32'(bus.rsp_rdata), 32'hA5);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);           // handshake edge follows
    @(negedge clk);
    check("bp_gap_req_ready", 32'(bus.req_ready), 32'd1);
    check("bp_gap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("bp_accepted_next", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_rsp(W, "lat_load_pending");
    wait_done();

    // reset in the middle of a store
    wlog_addr.delete();
    wlog_data.delete();
    issue(1'b1, 14'h0020, 8'hFF, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 clear_n = 1'b0;
    #1;
    check("midrst_mem_store", 32'(mem_store), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || mem_store) seen = 1'b1;
    end
    check("midrst_no_activity", 32'(seen), 32'd0);
    check("midrst_nwrites", 32'(wlog_addr.size()), 32'd3);
    for (int i = 0; i < W; i++) begin
      check("midrst_ram_bit", 32'(ram[14'h0020 + i]), (i < 3) ? 32'd1 : 32'd0);
    end
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // store into a word containing a stuck-at-0 bit
    issue(1'b1, 14'h0040, 8'hFF, 1'b1, VERIFY_ON ? 8'hDF : 8'h00, VERIFY_ON);
    wait_rsp(STORE_LAT, "lat_store_verify");
    wait_done();
    issue(1'b0, 14'h0040, 8'h00, 1'b1, 8'hDF, 1'b0);
    wait_rsp(W, "lat_load_stuck");
    wait_done();

    // 12-bit instance: initial image load
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b0;
    bus2.req_addr  = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.req_ready && n < 100);
    check("w12_accept", 32'(bus2.req_ready), 32'd1);
    sbq2.push_back(12'h538);
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus2.rsp_valid && n < 200);
    check("w12_lat", 32'(n), 32'(W2));
    repeat (4) @(posedge clk);
    #1;

    check("sb_drained", 32'(sbq.size()), 32'd0);
    check("sb2_drained", 32'(sbq2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_ram_word_master.md
# bit_ram_word_master

Initiator for the 1-bit-wide, 14-bit-addressed bit RAM. It accepts whole-word load/store requests from the datapath and serialises each one into WORD_W consecutive single-bit RAM accesses on one RAM port. It then returns the assembled word, or a write completion, through a valid/ready response channel. One instance drives one RAM port; several instances share the RAM in parallel.

## Interface

Parameters:
- WORD_W, 8, bits per word transfer (legal range 1–17).
- ADDR_W, 14, RAM bit-address width. The address space is 2^ADDR_W bits.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store word, 0 = load word.
- req_addr  input  ADDR_W  bit address of the word's MSB.
- req_wdata  input  WORD_W  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  WORD_W  loaded word. For stores: the read-back word when verify is enabled, else 0.
- rsp_err  output  1  write-verify mismatch.
- mem_address  output  ADDR_W  to the RAM port address.
- mem_datain  output  1  to the RAM port write data.
- mem_store  output  1  to the RAM port write enable.
- mem_dataout  input  1  from the RAM port. This is combinational read data for mem_address.

## Operation

- Bit order: word bit WORD_W-1-i maps to RAM address req_addr+i, so the MSB is at the base address.
- Address arithmetic is modulo 2^ADDR_W. A word that crosses the top of the address space wraps to address 0.
- States: IDLE, XFER, VERIFY (only with the macro), RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr, wdata and write; set count=0; go to XFER.
- XFER, one bit per cycle:
  - mem_address = base+count.
  - Store: mem_store=1 and mem_datain = wdata[WORD_W-1-count].
  - Load: mem_store=0, and mem_dataout is shifted into the read register at the clock edge.
  - At count==WORD_W-1, go to RESP. With the macro, a store goes to VERIFY instead.
- VERIFY: re-reads the same WORD_W addresses as a load does, with mem_store=0. It then goes to RESP.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err stable.
  - Holds until rsp_valid&&rsp_ready, then returns to IDLE.
- req_ready is 0 in every state except IDLE. Requests presented outside IDLE are not accepted and are not lost; the requester keeps req_valid high.
- The response handshake and a new acceptance never occur in the same cycle. The next request is accepted at the earliest one cycle after the response handshake.
- mem_address, mem_datain and mem_store are decoded from registers only. There is no combinational path from req_* or rsp_ready to mem_*.

## Timing

- Reset (clear_n low, asynchronous) forces:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_store=0, mem_datain=0, mem_address=0.
- Reset in the middle of a transfer aborts it:
  - RAM bits already written stay written.
  - No further stores are issued.
  - No response is produced.
- Request accepted at edge E0: the RAM is accessed in the WORD_W cycles after E0, and rsp_valid rises at edge E(WORD_W).
- With the macro, a store's rsp_valid rises at E(2·WORD_W).
- A load followed by an immediate rsp_ready gives WORD_W+2 cycles request-to-request throughput.
- Each RAM write occurs at the rising edge that ends its XFER cycle.

## Configuration

- Macro: BIT_RAM_MASTER_WRITE_VERIFY_EN.
- Defined:
  - Stores pass through VERIFY.
  - rsp_rdata holds the read-back word.
  - rsp_err=1 if the read-back word differs from wdata.
  - rsp_err is always 0 for loads.
- Undefined:
  - The VERIFY state is not built.
  - Store responses follow XFER directly.
  - rsp_rdata=0 and rsp_err=0 for stores.

## Test plan

- Store then load: store 0xA5 at 0x0010, then load from 0x0010.
  - rsp_rdata=0xA5.
  - mem_store high for exactly 8 cycles, writing addresses 0x0010..0x0017 with bits 1,0,1,0,0,1,0,1.
- Wrap: store 0x3C at 0x3FFC.
  - RAM addresses 0x3FFC..0x3FFF and 0x0000..0x0003 are written.
  - Loading from 0x3FFC returns 0x3C.
- Backpressure: during a load, hold rsp_ready=0 for 5 cycles.
  - rsp_valid stays 1 and rsp_rdata is stable.
  - req_ready=0 while req_valid=1 is presented.
  - The pending request is accepted exactly one cycle after the handshake.
- Reset mid-store: store 0xFF at 0x0020 into zeroed RAM, and pull clear_n low after 3 written bits.
  - mem_store drops immediately.
  - 0x0020..0x0022 read 1 and 0x0023..0x0027 read 0.
  - No rsp_valid is produced.
  - req_ready=1 after reset.
- Verify, with the macro: the RAM model forces address 0x0042 stuck at 0; store 0xFF at 0x0040.
  - rsp_err=1, rsp_rdata=0xDF.
  - rsp_valid rises 16 cycles after acceptance.
  - Without the macro: rsp_err=0 and rsp_valid rises after 8 cycles.
- Load of the initial RAM image from 0x0000 with WORD_W=12: rsp_rdata=0x538.
